spi_actuator_ctrl: RTL and testbench
====================================

// Module: spi_actuator_ctrl
// PURPOSE
//  User-area SPI slave and actuator register block behind the Caravel mprj_io pads.
//  A host shifts WORD_W-bit frames in. Each committed frame is echoed back MSB-first
//  on MISO during the next frame (passthrough). The frame is also latched into an
//  actuator drive register.
//  All logic runs on the single system clock; SPI pins are oversampled.
// PARAMETERS
//  WORD_W       32  SPI frame / data register width
//  SYNC_STAGES  2   synchronizer depth for ss_n, sclk, mosi and the *_n controls
//  ACT_W        16  actuator output width; act_out = active_reg[ACT_W-1:0]
// PORTS
//  wb_clk_i      in   1       system clock (~40 MHz); sclk must be <= clk/4
//  wb_rst_i      in   1       asynchronous, active-high reset
//  enable_n      in   1       async; low = block enabled
//  trigger_in_n  in   1       async; low = actuator outputs driven
//  latch_data_n  in   1       async; low = committed frame copied to active_reg
//  sclk          in   1       SPI clock, idle low, sample on rising edge (mode 0)
//  mosi          in   1       SPI data in, MSB first
//  ss_n          in   1       SPI slave select, active low
//  miso          out  1       SPI data out, MSB first
//  miso_oeb      out  1       pad output-enable, active low
//  act_out       out  ACT_W   actuator drive
//  frame_done    out  1       1-cycle pulse per committed frame
// BEHAVIOUR
//  Reset: all registers 0; miso=0, miso_oeb=1, act_out=0, frame_done=0.
//  Inputs pass through SYNC_STAGES flops. sclk/ss_n edges are detected on synced
//   values. mosi is delayed by the same depth so it aligns with sclk.
//  Frame start: synced ss_n falls -> bit_cnt=0, rx_shift=0.
//  Synced sclk rise with ss_n low:
//   rx_shift <= {rx_shift[WORD_W-2:0], mosi_s}; bit_cnt++ (saturates at WORD_W);
//   tx_shift <= tx_shift << 1 (next bit valid before the next sclk rise).
//  miso = tx_shift[WORD_W-1], registered. MSB is stable whenever ss_n is high,
//   so bit 0 of a frame is valid before the first sclk rise.
//  miso_oeb = enable_n_s (0 while enabled), regardless of ss_n.
//  Frame end: synced ss_n rises.
//   Commit if enable_n_s==0 (and bit_cnt==WORD_W when the macro is defined).
//   On commit: shadow_reg<=rx_shift, tx_shift<=rx_shift, frame_done pulses 1 cycle.
//   Not committed: tx_shift reloads shadow_reg (the last good word).
//   Either way, a word sent in frame N is returned in frame N+1.
//  latch_data_n_s==0 -> active_reg follows shadow_reg every cycle. High -> active_reg holds.
//  act_out = (trigger_in_n_s==0 && enable_n_s==0) ? active_reg[ACT_W-1:0] : 0, registered.
//  enable_n high mid-frame: shifting continues, but no commit at frame end.
//  ss_n rise and sclk rise in the same cycle: process the sclk rise first, then commit.
//  Reset mid-frame: immediate clear; next frame echoes 0.
// CONFIGURATION
//  SPI_BITCOUNT_CHECK_EN defined: commit only frames with exactly WORD_W sclk rises.
//   Short frames are discarded. Frames with more than WORD_W rises are discarded too:
//   a sticky overflow flag is set on a rise at bit_cnt==WORD_W.
//  Undefined: any frame commits with the rx_shift contents (last WORD_W bits received).
// TESTING
//  1. Reset, ss_n=1 -> miso_oeb=1, act_out=0, miso=0.
//  2. enable_n=0; frame 0xBEEFFACE, then frame 0x00000000 -> MISO reads 0xBEEFFACE in frame 2.
//  3. Frame 3 after 2 -> MISO reads 0x00000000; frame_done pulses once per frame.
//  4. latch_data_n=0, trigger_in_n=0, frame 0x1234A5C3 -> act_out=0xA5C3.
//     trigger_in_n=1 -> act_out=0.
//  5. enable_n=1, frame 0xDEADBEEF -> no frame_done. Next frame echoes the prior word.
//  6. With SPI_BITCOUNT_CHECK_EN: 31-bit frame -> discarded. Without it: committed.

Source files
------------

// File: rtl/spi_actuator_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_actuator_ctrl
// Description : Mode-0 SPI slave with frame passthrough echo and an actuator
//               drive register. All pins are oversampled on wb_clk_i.
//               Optional macro SPI_BITCOUNT_CHECK_EN: commit only frames that
//               carry exactly WORD_W sclk rises.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_actuator_ctrl #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACT_W       = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable_n,
  input  logic             trigger_in_n,
  input  logic             latch_data_n,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             ss_n,
  output logic             miso,
  output logic             miso_oeb,
  output logic [ACT_W-1:0] act_out,
  output logic             frame_done
);

  localparam int unsigned      c_CNT_W    = $clog2(WORD_W + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WORD_W);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  // Synchronizer reset values, order {latch_data_n, trigger_in_n, enable_n,
  // ss_n, sclk, mosi}: active-low controls and ss_n come up inactive so no
  // spurious frame edge or enable is seen when reset releases.
  localparam logic [5:0]       c_SYNC_RST = 6'b111100;

  logic [5:0] w_async;
  logic [5:0] w_sync;

  assign w_async = {latch_data_n, trigger_in_n, enable_n, ss_n, sclk, mosi};

  genvar g;
  generate
    for (g = 0; g < 6; g++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;
      // Multi-flop synchronizer; every pin sees the same depth so mosi stays
      // aligned with sclk.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) chain_q <= {SYNC_STAGES{c_SYNC_RST[g]}};
        else          chain_q <= {chain_q[SYNC_STAGES-2:0], w_async[g]};
      end
      assign w_sync[g] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  logic mosi_s, sclk_s, ss_n_s, enable_n_s, trigger_in_n_s, latch_data_n_s;
  assign mosi_s         = w_sync[0];
  assign sclk_s         = w_sync[1];
  assign ss_n_s         = w_sync[2];
  assign enable_n_s     = w_sync[3];
  assign trigger_in_n_s = w_sync[4];
  assign latch_data_n_s = w_sync[5];

  logic               sclk_prev_q, ss_prev_q;
  logic [c_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]  rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0]  tx_shift_q, tx_shift_d;
  logic [WORD_W-1:0]  shadow_q, shadow_d;
  logic [ACT_W-1:0]   active_q;
  logic [ACT_W-1:0]   act_q;
  logic               miso_q;
  logic               frame_done_q;
  logic               commit_d;
  logic               len_ok;
  logic               sclk_rise, ss_fall, ss_rise, shift_en;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ss_fall   = ss_prev_q & ~ss_n_s;
  assign ss_rise   = ~ss_prev_q & ss_n_s;
  // Qualify with the previous ss_n so an sclk rise coinciding with the ss_n
  // rise is still shifted in before the commit decision.
  assign shift_en  = sclk_rise & ~ss_prev_q;

`ifdef SPI_BITCOUNT_CHECK_EN
  logic ovf_q, ovf_d;

  // Sticky flag for frames carrying more than WORD_W sclk rises.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  // Overflow next-state: cleared at frame start, set on a rise at full count.
  always_comb begin
    ovf_d = ovf_q;
    if (ss_fall)                                   ovf_d = 1'b0;
    else if (shift_en && (bit_cnt_q == c_CNT_FULL)) ovf_d = 1'b1;
  end

  assign len_ok = (bit_cnt_d == c_CNT_FULL) && !ovf_d;
`else
  assign len_ok = 1'b1;
`endif

  // Frame datapath: shifting, bit counting and the commit/reload decision.
  always_comb begin
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    shadow_d   = shadow_q;
    commit_d   = 1'b0;
    if (ss_fall) begin
      rx_shift_d = '0;
      bit_cnt_d  = '0;
    end else if (shift_en) begin
      rx_shift_d = {rx_shift_q[WORD_W-2:0], mosi_s};
      tx_shift_d = tx_shift_q << 1;
      if (bit_cnt_q != c_CNT_FULL) bit_cnt_d = bit_cnt_q + c_CNT_ONE;
    end
    if (ss_rise) begin
      if (!enable_n_s && len_ok) begin
        shadow_d   = rx_shift_d;
        tx_shift_d = rx_shift_d;
        commit_d   = 1'b1;
      end else begin
        // Rejected frame: replay the last good word next time.
        tx_shift_d = shadow_q;
      end
    end
  end

  // State registers for the SPI engine and outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sclk_prev_q  <= 1'b0;
      ss_prev_q    <= 1'b1;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      shadow_q     <= '0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_s;
      ss_prev_q    <= ss_n_s;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      shadow_q     <= shadow_d;
      miso_q       <= tx_shift_d[WORD_W-1];
      frame_done_q <= commit_d;
    end
  end

  // Actuator path; only the low ACT_W bits of the active word reach the pads,
  // so only those bits are kept.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      active_q <= '0;
      act_q    <= '0;
    end else begin
      if (!latch_data_n_s) active_q <= shadow_q[ACT_W-1:0];
      act_q <= (!trigger_in_n_s && !enable_n_s) ? active_q : '0;
    end
  end

  assign miso       = miso_q;
  assign miso_oeb   = enable_n_s;
  assign act_out    = act_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_actuator_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_actuator_ctrl
// Description : Self-checking bench for spi_actuator_ctrl with an echo /
//               frame_done scoreboard. Honours SPI_BITCOUNT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_actuator_ctrl;

  localparam int HALF = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic enable_n = 1'b1, trigger_in_n = 1'b1, latch_data_n = 1'b1;
  logic sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic miso, miso_oeb, frame_done;
  logic [15:0] act_out;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  logic [31:0] m_shadow = '0;
  logic [31:0] m_tx = '0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          fde_q[$];
  int          fdg_q[$];

  spi_actuator_ctrl #(.WORD_W(32), .SYNC_STAGES(2), .ACT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable_n(enable_n),
    .trigger_in_n(trigger_in_n), .latch_data_n(latch_data_n),
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso),
    .miso_oeb(miso_oeb), .act_out(act_out), .frame_done(frame_done)
  );

  always #12 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master drives one frame, captures MISO and pushes expectations.
  task automatic run_frame(input logic [31:0] word, input int nbits);
    logic [31:0] got;
    logic [31:0] rx;
    bit          commit;
    int          fd0;
    got = '0;
    exp_q.push_back(m_tx >> (32 - nbits));
    fd0 = fd_cnt;
    ss_n = 1'b0;
    cyc(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = word[i];
      cyc(HALF);
      got = {got[30:0], miso};
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
    end
    cyc(HALF);
    ss_n = 1'b1;
    cyc(2 * HALF);
    got_q.push_back(got);
    rx = (nbits >= 32) ? word : (word & ((32'h1 << nbits) - 32'h1));
`ifdef SPI_BITCOUNT_CHECK_EN
    commit = (enable_n == 1'b0) && (nbits == 32);
`else
    commit = (enable_n == 1'b0);
`endif
    if (commit) begin
      m_shadow = rx;
      m_tx     = rx;
    end else begin
      m_tx = m_shadow;
    end
    fde_q.push_back(commit ? 1 : 0);
    fdg_q.push_back(fd_cnt - fd0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
    checks++; if (miso_oeb !== 1'b1) begin errors++; $display("FAIL reset_oeb got %b exp 1", miso_oeb); end
    checks++; if (act_out !== 16'h0) begin errors++; $display("FAIL reset_act got %h exp 0000", act_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
    rst = 1'b0;
    enable_n = 1'b0;
    cyc(6);
    checks++; if (miso_oeb !== 1'b0) begin errors++; $display("FAIL enabled_oeb got %b exp 0", miso_oeb); end
  endtask

  task automatic test_passthrough;
    logic [31:0] e, gt;
    int fe, fg;
    run_frame(32'hBEEFFACE, 32);
    run_frame(32'h00000000, 32);
    run_frame(32'h00000000, 32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); gt = got_q.pop_front();
      fe = fde_q.pop_front(); fg = fdg_q.pop_front();
      checks++; if (gt !== e) begin errors++; $display("FAIL pass_echo got %h exp %h", gt, e); end
      checks++; if (fg != fe) begin errors++; $display("FAIL pass_done got %0d exp %0d", fg, fe); end
    end
  endtask

  task automatic test_actuator;
    logic [31:0] e, gt;
    int fe, fg;
    latch_data_n = 1'b0;
    trigger_in_n = 1'b0;
    run_frame(32'h1234A5C3, 32);
    cyc(8);
    checks++; if (act_out !== 16'hA5C3) begin errors++; $display("FAIL act_drive got %h exp a5c3", act_out); end
    trigger_in_n = 1'b1;
    cyc(6);
    checks++; if (act_out !== 16'h0000) begin errors++; $display("FAIL act_untrig got %h exp 0000", act_out); end
    latch_data_n = 1'b1;
    trigger_in_n = 1'b0;
    cyc(6);
    run_frame(32'h5555AAAA, 32);
    cyc(8);
    checks++; if (act_out !== 16'hA5C3) begin errors++; $display("FAIL act_hold got %h exp a5c3", act_out); end
    trigger_in_n = 1'b1;
    cyc(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); gt = got_q.pop_front();
      fe = fde_q.pop_front(); fg = fdg_q.pop_front();
      checks++; if (gt !== e) begin errors++; $display("FAIL act_echo got %h exp %h", gt, e); end
      checks++; if (fg != fe) begin errors++; $display("FAIL act_done got %0d exp %0d", fg, fe); end
    end
  endtask

  task automatic test_disable;
    logic [31:0] e, gt;
    int fe, fg;
    enable_n = 1'b1;
    cyc(4);
    checks++; if (miso_oeb !== 1'b1) begin errors++; $display("FAIL dis_oeb got %b exp 1", miso_oeb); end
    run_frame(32'hDEADBEEF, 32);
    enable_n = 1'b0;
    cyc(4);
    run_frame(32'h0F0F0F0F, 32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); gt = got_q.pop_front();
      fe = fde_q.pop_front(); fg = fdg_q.pop_front();
      checks++; if (gt !== e) begin errors++; $display("FAIL dis_echo got %h exp %h", gt, e); end
      checks++; if (fg != fe) begin errors++; $display("FAIL dis_done got %0d exp %0d", fg, fe); end
    end
  endtask

  task automatic test_bitcount;
    logic [31:0] e, gt;
    int fe, fg;
    run_frame(32'hA1B2C3D4, 32);
    run_frame(32'h76543210, 31);
    run_frame(32'h00000000, 32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); gt = got_q.pop_front();
      fe = fde_q.pop_front(); fg = fdg_q.pop_front();
      checks++; if (gt !== e) begin errors++; $display("FAIL bc_echo got %h exp %h", gt, e); end
      checks++; if (fg != fe) begin errors++; $display("FAIL bc_done got %0d exp %0d", fg, fe); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e, gt;
    int fe, fg;
    for (int k = 0; k < 6; k++) run_frame($urandom, 32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); gt = got_q.pop_front();
      fe = fde_q.pop_front(); fg = fdg_q.pop_front();
      checks++; if (gt !== e) begin errors++; $display("FAIL b2b_echo got %h exp %h", gt, e); end
      checks++; if (fg != fe) begin errors++; $display("FAIL b2b_done got %0d exp %0d", fg, fe); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] e, gt;
    int fe, fg;
    run_frame(32'hFFFF0000, 32);
    ss_n = 1'b0;
    cyc(HALF);
    for (int i = 0; i < 10; i++) begin
      mosi = i[0];
      cyc(HALF);
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
    end
    rst = 1'b1;
    cyc(1);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL mid_rst_miso got %b exp 0", miso); end
    ss_n = 1'b1;
    cyc(3);
    rst = 1'b0;
    m_shadow = '0;
    m_tx = '0;
    exp_q.delete(); got_q.delete(); fde_q.delete(); fdg_q.delete();
    cyc(6);
    run_frame(32'hCAFE1234, 32);
    run_frame(32'h00000000, 32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); gt = got_q.pop_front();
      fe = fde_q.pop_front(); fg = fdg_q.pop_front();
      checks++; if (gt !== e) begin errors++; $display("FAIL mid_echo got %h exp %h", gt, e); end
      checks++; if (fg != fe) begin errors++; $display("FAIL mid_done got %0d exp %0d", fg, fe); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_actuator();
    test_disable();
    test_bitcount();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
